// File: rtl/video_timing.sv
// Raster timing generator: walks a pixel/line counter pair across a full frame and
// presents registered beam position, visible flag, sync pulses, line/frame strobes,
// a completed-frame counter and a sticky vblank interrupt for the CPU.
module video_timing #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pixel_en,
   input  logic        vblank_ack,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        visible,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic        vblank_irq,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

   // Region boundaries are 17 bits wide: a sync region may end exactly at 65536.
   localparam logic [16:0] H_VIS_END  = 17'(H_VISIBLE);
   localparam logic [16:0] H_SYNC_BEG = 17'(H_VISIBLE + H_FRONT);
   localparam logic [16:0] H_SYNC_END = 17'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [16:0] V_VIS_END  = 17'(V_VISIBLE);
   localparam logic [16:0] V_SYNC_BEG = 17'(V_VISIBLE + V_FRONT);
   localparam logic [16:0] V_SYNC_END = 17'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [15:0] IRQ_LINE   = 16'(V_VISIBLE);

   logic [15:0] hc;
   logic [15:0] vc;
   logic        fresh;    // first decode after reset release: origin shown without a step
   logic        step_q;   // counters advanced on the previous clk, so (hc,vc) is a new position

   logic        h_vis;
   logic        v_vis;
   logic        h_sync_on;
   logic        v_sync_on;
   logic        new_pos;
   logic        at_line0;
   logic        at_origin;
   logic        irq_set;

   assign h_vis     = {1'b0, hc} < H_VIS_END;
   assign v_vis     = {1'b0, vc} < V_VIS_END;
   assign h_sync_on = ({1'b0, hc} >= H_SYNC_BEG) && ({1'b0, hc} < H_SYNC_END);
   assign v_sync_on = ({1'b0, vc} >= V_SYNC_BEG) && ({1'b0, vc} < V_SYNC_END);
   assign new_pos   = step_q || fresh;
   assign at_line0  = (hc == 16'd0);
   assign at_origin = at_line0 && (vc == 16'd0);
   assign irq_set   = at_line0 && (vc == IRQ_LINE) && step_q;

   // Pixel and line counters: advance on pixel_en, wrap at end of line and end of frame.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset_n) begin
         hc <= '0;
         vc <= '0;
      end else if (pixel_en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 16'd0 : vc + 16'd1;
         end else begin
            hc <= hc + 16'd1;
         end
      end
   end

   // Tracks whether the counter value about to be decoded is a newly reached position.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fresh  <= 1'b1;
         step_q <= 1'b0;
      end else begin
         fresh  <= 1'b0;
         step_q <= pixel_en;
      end
   end

   // Registered decode of the counters into the beam outputs (one clk behind hc/vc).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x           <= '0;
         y           <= '0;
         visible     <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= hc;
         y           <= vc;
         visible     <= h_vis && v_vis;
         hsync       <= h_sync_on ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= v_sync_on ? VSYNC_POL : ~VSYNC_POL;
         line_start  <= at_line0 && new_pos;
         frame_start <= at_origin && new_pos;
      end
   end

   // Completed-frame counter: counts wraps to the origin, not the origin after reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_count <= '0;
      end else if (at_origin && step_q) begin
         frame_count <= frame_count + 16'd1;
      end
   end

   // Sticky vblank interrupt: set on entering the first blanking line, set wins over ack.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vblank_irq <= 1'b0;
      end else if (irq_set) begin
         vblank_irq <= 1'b1;
      end else if (vblank_ack) begin
         vblank_irq <= 1'b0;
      end
   end

endmodule
